// File: rtl/cell_pos_reader_pkg.sv
// Shared definitions for the cell position reader: sequencer states and RAM timing.
package cell_pos_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_CNT  = 3'd1,
        ST_WAIT_CNT = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DRAIN    = 3'd4
    } state_e;

    localparam int unsigned MEM_RD_LAT = 2;

endpackage

// File: rtl/cell_pos_reader_pos_rd_fifo.sv
// Small circular buffer for returning position words; head is read straight from
// the storage registers, so a word written into an empty buffer appears next cycle.
module pos_rd_fifo #(
    parameter int unsigned WIDTH = 105,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    occ_q;
    logic             rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_en   = pop_i && (occ_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (rd_en) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            occ_q <= occ_q + CW'(push_i) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/cell_pos_reader.sv
// Read-side sequencer for one cell position RAM: fetches the particle count, then
// streams words 1..count through a credit-limited buffer onto a valid/ready port.
module cell_pos_reader
    import cell_pos_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 96,
    parameter int unsigned PARTICLE_NUM = 220,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned BUF_DEPTH    = 4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pos,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last
);

    localparam int unsigned FIFO_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [1:0]            wait_q, wait_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      in_flight_q, in_flight_d;
    logic [CNT_W-1:0]      occ;

    logic                  rd_vld_q  [MEM_RD_LAT];
    logic [ADDR_WIDTH-1:0] rd_addr_q [MEM_RD_LAT];

    logic                  issue;
    logic                  pop;
    logic                  ret_vld;
    logic                  ret_last;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic [ADDR_WIDTH-1:0] cnt_raw;
    logic [ADDR_WIDTH-1:0] cnt_clamped;
    logic [FIFO_W-1:0]     fifo_rdata;

    // Credit rule: buffered plus outstanding reads may never exceed the buffer size.
    assign issue = (state_q == ST_STREAM) &&
                   ((int'(occ) + int'(in_flight_q)) < int'(BUF_DEPTH));

    assign mem_rden    = issue || (state_q == ST_REQ_CNT);
    assign mem_address = issue ? next_addr_q : '0;
    assign mem_wren    = 1'b0;

    assign ret_vld  = rd_vld_q[MEM_RD_LAT-1];
    assign ret_addr = rd_addr_q[MEM_RD_LAT-1];
    assign ret_last = (ret_addr == count_q);

    assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
    assign cnt_clamped = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;

    assign out_valid = (occ != '0);
    assign pop       = out_valid && out_ready;
    assign {out_last, out_pid, out_pos} = fifo_rdata;

    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign particle_count = count_q;

    assign in_flight_d = in_flight_q + CNT_W'(issue) - CNT_W'(ret_vld);

    pos_rd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (rst_n),
        .push_i  (ret_vld),
        .wdata_i ({ret_last, ret_addr, mem_q}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .occ_o   (occ)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        next_addr_d = next_addr_q;
        wait_d      = wait_q;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_REQ_CNT;
            end
            ST_REQ_CNT: begin
                wait_d  = '0;
                state_d = ST_WAIT_CNT;
            end
            ST_WAIT_CNT: begin
                if (wait_q == 2'(MEM_RD_LAT - 1)) begin
                    count_d = cnt_clamped;
                    if (cnt_clamped == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        next_addr_d = ADDR_WIDTH'(1);
                        state_d     = ST_STREAM;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_STREAM: begin
                if (issue) begin
                    next_addr_d = next_addr_q + 1'b1;
                    if (next_addr_q == count_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Popping the last-tagged word means every read has returned and drained.
                if (pop && out_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            next_addr_q <= '0;
            wait_q      <= '0;
            done_q      <= 1'b0;
            in_flight_q <= '0;
            for (int unsigned i = 0; i < MEM_RD_LAT; i++) begin
                rd_vld_q[i]  <= 1'b0;
                rd_addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            next_addr_q  <= next_addr_d;
            wait_q       <= wait_d;
            done_q       <= done_d;
            in_flight_q  <= in_flight_d;
            rd_vld_q[0]  <= issue;
            rd_addr_q[0] <= next_addr_q;
            for (int unsigned i = 1; i < MEM_RD_LAT; i++) begin
                rd_vld_q[i]  <= rd_vld_q[i-1];
                rd_addr_q[i] <= rd_addr_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_cell_pos_reader.sv
// Randomised bench for cell_pos_reader: behavioural RAM with 2-cycle read latency
// and an expected-word queue built directly from the RAM contents.
module tb_cell_pos_reader;

    localparam int unsigned DW = 96;
    localparam int unsigned PN = 220;
    localparam int unsigned AW = 8;
    localparam int unsigned BD = 4;

    typedef struct {
        logic [DW-1:0] pos;
        logic [AW-1:0] pid;
        logic          last;
    } word_t;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] particle_count;
    logic [AW-1:0] mem_address;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pos;
    logic [AW-1:0] out_pid;
    logic          out_last;

    always #5 clock = ~clock;

    cell_pos_reader #(
        .DATA_WIDTH   (DW),
        .PARTICLE_NUM (PN),
        .ADDR_WIDTH   (AW),
        .BUF_DEPTH    (BD)
    ) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .particle_count (particle_count),
        .mem_address    (mem_address),
        .mem_rden       (mem_rden),
        .mem_wren       (mem_wren),
        .mem_q          (mem_q),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pos        (out_pos),
        .out_pid        (out_pid),
        .out_last       (out_last)
    );

    // Behavioural RAM: data for a read enabled in cycle T is visible in cycle T+2.
    logic [DW-1:0] ram [PN];
    logic [DW-1:0] rq1 = '0;
    logic [DW-1:0] rq2 = '0;
    always @(posedge clock) begin
        rq1 <= mem_rden ? ram[mem_address] : '0;
        rq2 <= rq1;
    end
    assign mem_q = rq2;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    ready_mode = 0;
    int    ready_ph = 0;
    int    first_valid_cyc = -1;
    int    last_hs_cyc = -1;
    int    done_cyc = -1;
    int    done_cnt = 0;
    int    hs_cnt = 0;
    int    rd_addrs[$];
    word_t exp_q[$];
    word_t mon_w;

    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_pos = '0;
    logic [AW-1:0] prev_pid = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rst_n) begin
            chk("wren", 128'(mem_wren), 128'(0));
            chk("credit", 128'((int'(dut.occ) + int'(dut.in_flight_q)) <= int'(BD)), 128'(1));
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 128'(out_valid), 128'(1));
                chk("hold_pos", 128'(out_pos), 128'(prev_pos));
                chk("hold_pid", 128'(out_pid), 128'(prev_pid));
                chk("hold_last", 128'(out_last), 128'(prev_last));
            end
            if (mem_rden) rd_addrs.push_back(int'(mem_address));
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("extra_word", 128'(out_pid), 128'(0));
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("pos", 128'(out_pos), 128'(mon_w.pos));
                    chk("pid", 128'(out_pid), 128'(mon_w.pid));
                    chk("last", 128'(out_last), 128'(mon_w.last));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", 128'(busy), 128'(0));
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_pos   = out_pos;
            prev_pid   = out_pid;
            prev_last  = out_last;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((ready_ph % 4) == 0) || ((ready_ph % 4) == 3);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        ready_ph++;
    endtask

    // Fills the RAM and derives the expected stream: pids 1..min(count, PN-1).
    task automatic load_ram(input logic [7:0] cnt_raw, output int ec);
        logic [DW-1:0] w;
        for (int i = 1; i < int'(PN); i++) ram[i] = {$urandom(), $urandom(), $urandom()};
        w = {$urandom(), $urandom(), $urandom()};
        w[7:0] = cnt_raw;
        ram[0] = w;
        ec = (int'(cnt_raw) > int'(PN) - 1) ? int'(PN) - 1 : int'(cnt_raw);
        exp_q.delete();
        for (int p = 1; p <= ec; p++) begin
            word_t e;
            e.pos  = ram[p];
            e.pid  = AW'(p);
            e.last = (p == ec);
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_logs();
        done_cnt = 0;
        first_valid_cyc = -1;
        last_hs_cyc = -1;
        done_cyc = -1;
        hs_cnt = 0;
        rd_addrs.delete();
    endtask

    task automatic run_stream(input logic [7:0] cnt_raw, input int rmode,
                              input int restart_at, input int post_idle);
        int ec;
        int start_cyc;
        int nrd;
        load_ram(cnt_raw, ec);
        clear_logs();
        ready_mode = rmode;
        ready_ph = 0;
        step();
        start = 1'b1;
        start_cyc = cyc;
        for (int i = 1; i < 3000 && done_cnt == 0; i++) begin
            step();
            start = (i == restart_at);
            @(negedge clock);
            #1;
            if (i == 1) chk("busy_after_start", 128'(busy), 128'(1));
        end
        start = 1'b0;
        chk("done_seen", 128'(done_cnt > 0), 128'(1));
        for (int i = 0; i < post_idle; i++) begin
            step();
            @(negedge clock);
            #1;
            chk("idle_busy", 128'(busy), 128'(0));
        end
        chk("done_pulses", 128'(done_cnt), 128'(1));
        chk("pcount", 128'(particle_count), 128'(ec));
        chk("words_left", 128'(exp_q.size()), 128'(0));
        chk("hs_cnt", 128'(hs_cnt), 128'(ec));
        chk("rd_num", 128'(rd_addrs.size()), 128'(ec + 1));
        nrd = (rd_addrs.size() < ec + 1) ? rd_addrs.size() : ec + 1;
        for (int k = 0; k < nrd; k++) chk("rd_addr", 128'(rd_addrs[k]), 128'(k));
        if (ec == 0) begin
            chk("done_lat_cnt0", 128'(done_cyc - start_cyc), 128'(4));
            chk("no_valid_cnt0", 128'(first_valid_cyc < 0), 128'(1));
        end else begin
            // start, REQ_CNT, two wait cycles, issue pid 1, two-cycle return, buffer register
            chk("first_valid_lat", 128'(first_valid_cyc - start_cyc), 128'(7));
            chk("done_after_last", 128'(done_cyc - last_hs_cyc), 128'(1));
        end
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_pos"}, 128'(out_pos), 128'(0));
        chk({tag, "_pid"}, 128'(out_pid), 128'(0));
        chk({tag, "_last"}, 128'(out_last), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_rden"}, 128'(mem_rden), 128'(0));
        chk({tag, "_addr"}, 128'(mem_address), 128'(0));
        chk({tag, "_pcount"}, 128'(particle_count), 128'(0));
    endtask

    initial begin
        int  ec;
        bit  found;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < PN; i++) ram[i] = '0;
        ready_mode = 3;
        step();
        step();
        reset_outputs_zero("por");
        rst_n = 1'b1;
        step();

        run_stream(8'd5, 0, -1, 2);
        run_stream(8'd0, 0, -1, 2);
        run_stream(8'd8, 1, -1, 2);
        run_stream(8'd255, 2, -1, 2);
        run_stream(8'd8, 1, 9, 0);
        run_stream(8'd3, 0, -1, 2);

        // Reset with three words buffered and one read outstanding.
        load_ram(8'd30, ec);
        clear_logs();
        ready_mode = 3;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            #1;
            if (int'(dut.occ) == 3 && int'(dut.in_flight_q) == 1) found = 1'b1;
        end
        chk("rst_setup", 128'(found), 128'(1));
        rst_n = 1'b0;
        #1;
        reset_outputs_zero("midrst");
        step();
        step();
        rst_n = 1'b1;
        exp_q.delete();
        run_stream(8'd2, 0, -1, 2);

        for (int r = 0; r < 6; r++) begin
            run_stream(8'($urandom_range(0, 40)), int'($urandom_range(0, 2)), -1,
                       int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
